// File: rtl/gpio_debounce_irq_pkg.sv
// Shared types and sizing helpers for the GPIO debounce/irq block.
package gpio_debounce_pkg;

  typedef enum logic {ST_INIT, ST_RUN} gpio_db_state_e;

  // Bits needed to hold values 0..cycles.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/gpio_debounce_irq_if.sv
// GPIO conditioner bus: raw pins and irq controls in, debounced levels/edges/pending out.
interface gpio_debounce_irq_if #(
  parameter int NUM_CH = 16
);
  logic [NUM_CH-1:0] raw_i;
  logic [NUM_CH-1:0] rise_en_i;
  logic [NUM_CH-1:0] fall_en_i;
  logic [NUM_CH-1:0] clr_i;
  logic [NUM_CH-1:0] level_o;
  logic [NUM_CH-1:0] rise_o;
  logic [NUM_CH-1:0] fall_o;
  logic [NUM_CH-1:0] pending_o;
  logic              irq_o;

  modport slave (
    input  raw_i, rise_en_i, fall_en_i, clr_i,
    output level_o, rise_o, fall_o, pending_o, irq_o
  );

  modport master (
    output raw_i, rise_en_i, fall_en_i, clr_i,
    input  level_o, rise_o, fall_o, pending_o, irq_o
  );
endinterface

// File: rtl/gpio_debounce_irq_ch.sv
// One input channel: synchroniser chain, stable-cycle counter, debounced level and edge pulses.
module gpio_debounce_ch
  import gpio_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw_i};
    s       = sync_q[SYNC_STAGES-1];
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    // Before RUN the level tracks the input directly so a pin already high at reset is not an edge.
    if (!run_i) begin
      level_d = s;
    end else if (s != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = s;
        rise_d  = s;
        fall_d  = ~s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/gpio_debounce_irq.sv
// GPIO input conditioner: NUM_CH debounced channels, INIT/RUN start-up FSM, sticky edge-pending and irq.
// Pending/irq logic is present only when GPIO_DEBOUNCE_IRQ_EN is defined.
module gpio_debounce_irq
  import gpio_debounce_pkg::*;
#(
  parameter int NUM_CH          = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  gpio_debounce_irq_if.slave   bus
);
  localparam int            IW        = cnt_width(SYNC_STAGES);
  localparam logic [IW-1:0] INIT_LAST = IW'(SYNC_STAGES);

  gpio_db_state_e    state_q;
  logic [IW-1:0]     init_cnt_q;
  logic              run_q;
  logic [NUM_CH-1:0] level, rise, fall;

  // INIT spans SYNC_STAGES+1 cycles so the synchroniser is flushed before edges count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      run_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (init_cnt_q == INIT_LAST) begin
            state_q <= ST_RUN;
            run_q   <= 1'b1;
          end else begin
            init_cnt_q <= init_cnt_q + 1'b1;
          end
        end
        ST_RUN:  run_q <= 1'b1;
        default: begin
          state_q <= ST_INIT;
          run_q   <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    gpio_debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .run_i  (run_q),
      .raw_i  (bus.raw_i[g]),
      .level_o(level[g]),
      .rise_o (rise[g]),
      .fall_o (fall[g])
    );
  end

  assign bus.level_o = level;
  assign bus.rise_o  = rise;
  assign bus.fall_o  = fall;

`ifdef GPIO_DEBOUNCE_IRQ_EN
  logic [NUM_CH-1:0] pending_q, pending_d;

  // Set term is OR'd after the clear so a same-cycle edge is never lost.
  always_comb begin
    pending_d = (pending_q & ~bus.clr_i) | (rise & bus.rise_en_i) | (fall & bus.fall_en_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign bus.pending_o = pending_q;
  assign bus.irq_o     = |pending_q;
`else
  logic unused_irq_ctrl;
  assign unused_irq_ctrl = ^{bus.rise_en_i, bus.fall_en_i, bus.clr_i};
  assign bus.pending_o   = '0;
  assign bus.irq_o       = 1'b0;
`endif

endmodule
